nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 tb/tb_nibble_serial_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: bit-serial-by-nibble adder/subtractor.
// One 4-bit adder slice is reused for WIDTH/4 cycles, walking from the least
// significant nibble upward and threading the carry through a register.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    // Captured operation; held for the whole run so input changes are ignored.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
    } req_t;

    logic [1:0]       state;
    req_t             op_q;
    logic [CW-1:0]    cnt;
    logic             c_q;
    logic [WIDTH-1:0] res_q;
    logic             ovf_q;

    logic [CW+1:0]    shamt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum;
    logic             c_msb;
    logic [WIDTH-1:0] nib_place;

    // Single nibble slice: select nibble cnt, optionally invert B, add with carry.
    // The carry into the nibble MSB is recovered from the sum bit instead of a
    // second adder: sum[3] = a[3] ^ b[3] ^ c_in3.
    always_comb begin
        shamt     = {cnt, 2'b00};
        a_sh      = op_q.a >> shamt;
        b_sh      = op_q.b >> shamt;
        a_nib     = a_sh[3:0];
        b_nib     = op_q.sub ? ~b_sh[3:0] : b_sh[3:0];
        sum       = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
        c_msb     = sum[3] ^ a_nib[3] ^ b_nib[3];
        nib_place = WIDTH'(sum[3:0]) << shamt;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            cnt   <= '0;
            c_q   <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= {a, b, sub};
                        c_q   <= sub;
                        cnt   <= '0;
                        res_q <= '0;
                        ovf_q <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // res_q was cleared on accept, so OR-ing the nibble in is a write.
                    res_q <= res_q | nib_place;
                    c_q   <= sum[4];
                    if (cnt == LAST) begin
                        ovf_q <= c_msb ^ sum[4];
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign carry     = c_q;
    assign overflow  = ovf_q;
    assign zero      = (res_q == '0);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at WIDTH 4, 8, 16 and 32.
// All four instances share the handshake and operand inputs (truncated per width).
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        sub;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;

    logic        ir4, ov4, c4, v4, z4;
    logic [3:0]  r4;
    logic        ir8, ov8, c8, v8, z8;
    logic [7:0]  r8;
    logic        ir16, ov16, c16, v16, z16;
    logic [15:0] r16;
    logic        ir32, ov32, c32, v32, z32;
    logic [31:0] r32;

    logic [3:0]  ir, ov, cy, vf, zf;
    logic [31:0] rs [4];

    int tot = 0;
    int bad = 0;
    int lat [4];
    int wk  [4] = '{4, 8, 16, 32};

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
        .a(a[3:0]), .b(b[3:0]), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
        .result(r4), .carry(c4), .overflow(v4), .zero(z4));
    nibble_serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ov8), .out_ready(out_ready),
        .result(r8), .carry(c8), .overflow(v8), .zero(z8));
    nibble_serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .out_valid(ov16), .out_ready(out_ready),
        .result(r16), .carry(c16), .overflow(v16), .zero(z16));
    nibble_serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .a(a), .b(b), .sub(sub), .out_valid(ov32), .out_ready(out_ready),
        .result(r32), .carry(c32), .overflow(v32), .zero(z32));

    assign ir = {ir32, ir16, ir8, ir4};
    assign ov = {ov32, ov16, ov8, ov4};
    assign cy = {c32, c16, c8, c4};
    assign vf = {v32, v16, v8, v4};
    assign zf = {z32, z16, z8, z4};
    assign rs[0] = {28'b0, r4};
    assign rs[1] = {24'b0, r8};
    assign rs[2] = {16'b0, r16};
    assign rs[3] = r32;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    // Reference: returns {zero, overflow, carry, result} for a width-w operation.
    function automatic logic [34:0] model(int w, logic [31:0] x, logic [31:0] y, logic s);
        logic [63:0] m, aa, bb, su, rr;
        logic c, v, z;
        m  = (64'd1 << w) - 64'd1;
        aa = {32'b0, x} & m;
        bb = (s ? ~{32'b0, y} : {32'b0, y}) & m;
        su = aa + bb + {63'b0, s};
        rr = su & m;
        c  = su[w];
        v  = (aa[w-1] == bb[w-1]) && (rr[w-1] != aa[w-1]);
        z  = (rr == 64'd0);
        return {z, v, c, rr[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Measures cycles from the accept edge to out_valid per instance.
    // With noisy set, in_valid/a/b/sub are scrambled while the run is in progress.
    task automatic wait_done(input bit noisy);
        for (int k = 0; k < 4; k++) lat[k] = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (ov[k] && lat[k] < 0) lat[k] = cyc;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0 && lat[3] >= 0) break;
            @(posedge clk); #1;
            a = $urandom; b = $urandom;
            sub = 1'($urandom);
            if (noisy) in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        chk("all_done", {60'b0, ov}, 64'hF);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s, input bit noisy);
        @(posedge clk); #1;
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(noisy);
    endtask

    task automatic finish_op();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_ack", {59'b0, ir, ov16}, {59'b0, 4'hF, 1'b0});
    endtask

    task automatic chk16(input string n, input logic [15:0] r, input logic c, input logic v, input logic z);
        chk({n, "_res"}, {48'b0, r16}, {48'b0, r});
        chk({n, "_cvz"}, {61'b0, c16, v16, z16}, {61'b0, c, v, z});
    endtask

    initial begin
        vec_t vt [8];
        int   cnt [4];
        bit   seen;
        logic [34:0] e;

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vt[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[5] = '{16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_ready", {60'b0, ir}, 64'hF);
        chk("rst_valid", {60'b0, ov}, 64'h0);
        chk16("rst", 16'h0000, 1'b0, 1'b0, 1'b1);

        // WIDTH=4 directed pair, single-cycle latency
        run_op(32'hF, 32'hF, 1'b0, 1'b0);
        chk("w4_lat", 64'(lat[0]), 64'd1);
        chk("w4_ff", {59'b0, r4, c4}, {59'b0, 4'hE, 1'b1});
        chk("w4_ff_vz", {62'b0, v4, z4}, 64'd0);
        finish_op();
        run_op(32'hE, 32'h1, 1'b0, 1'b0);
        chk("w4_e1", {59'b0, r4, c4}, {59'b0, 4'hF, 1'b0});
        finish_op();

        // WIDTH=16 table
        for (int i = 0; i < 8; i++) begin
            run_op({16'h0, vt[i].a}, {16'h0, vt[i].b}, vt[i].sub, 1'b0);
            chk($sformatf("vec%0d_lat", i), 64'(lat[2]), 64'd4);
            chk16($sformatf("vec%0d", i), vt[i].r, vt[i].c, vt[i].v, vt[i].z);
            finish_op();
        end

        // Back-pressure: outputs held while out_ready stays low
        run_op(32'h7FFF, 32'h1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk16($sformatf("hold%0d", i), 16'h8000, 1'b0, 1'b1, 1'b0);
            chk($sformatf("hold%0d_hs", i), {62'b0, ov16, ir16}, {62'b0, 1'b1, 1'b0});
        end
        finish_op();

        // Input noise during RUN must not disturb the captured operation
        run_op(32'h1234, 32'h1111, 1'b0, 1'b1);
        chk16("noisy", 16'h2345, 1'b0, 1'b0, 1'b0);
        finish_op();

        // Abort in RUN after step 1
        @(posedge clk); #1 a = 32'h5; b = 32'h6; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", {60'b0, ov}, 64'h0);
        chk16("abort", 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("abort_r32", {32'b0, r32}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov != 4'h0) seen = 1'b1;
        end
        chk("abort_no_valid", {63'b0, seen}, 64'h0);

        // Accept on the first edge after reset release
        @(posedge clk); #1 rst_n = 1'b0; a = 32'h3; b = 32'h4; sub = 1'b0; in_valid = 1'b1;
        #3 rst_n = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done(1'b0);
        chk("first_edge_lat", 64'(lat[2]), 64'd4);
        chk16("first_edge", 16'h0007, 1'b0, 1'b0, 1'b0);
        finish_op();

        // Random operands, random out_ready, all widths against the model
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom; sub = 1'($urandom); in_valid = 1'b1;
            for (int k = 0; k < 4; k++) cnt[k] = 0;
            @(posedge clk); #1 in_valid = 1'b0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                @(negedge clk);
                if (cyc > 0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (ov[k] && out_ready) begin
                            cnt[k]++;
                            e = model(wk[k], a, b, sub);
                            chk($sformatf("rnd%0d_w%0d_res", n, wk[k]), {32'b0, rs[k]}, {32'b0, e[31:0]});
                            chk($sformatf("rnd%0d_w%0d_cvz", n, wk[k]), {61'b0, cy[k], vf[k], zf[k]},
                                {61'b0, e[32], e[33], e[34]});
                        end
                    end
                end
                if (cnt[0] > 0 && cnt[1] > 0 && cnt[2] > 0 && cnt[3] > 0) break;
                @(posedge clk); #1 out_ready = 1'($urandom);
            end
            @(posedge clk); #1 out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) if (ov[k]) cnt[k]++;
            end
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++)
                chk($sformatf("rnd%0d_w%0d_count", n, wk[k]), 64'(cnt[k]), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
